// File: rtl/z80trace_pkg.sv
// Shared types for the Z80 bus-cycle tracer.
// Cycle type codes, FSM states and the trace record width.
package z80trace_pkg;

  localparam int TYPE_W = 3;

  typedef enum logic [TYPE_W-1:0] {
    T_FETCH = 3'd0,
    T_MRD   = 3'd1,
    T_MWR   = 3'd2,
    T_IORD  = 3'd3,
    T_IOWR  = 3'd4,
    T_INTA  = 3'd5
  } cyc_type_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_COMMIT
  } trc_state_t;

  function automatic int rec_width(input int aw, input int dw);
    return TYPE_W + aw + dw;
  endfunction

endpackage

// File: rtl/z80trace_fifo.sv
// Synchronous record FIFO: push/pop, full/empty, occupancy, drop pulse.
// Ports: clk, rst_n, push, wdata, pop, rdata, empty, full, count, drop.
module z80trace_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 27
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  pop,
  output logic [WIDTH-1:0]      rdata,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  drop
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (DEPTH_LOG2+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop on the same edge frees the slot a full FIFO needs.
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push & ~do_pop)
        count <= count + 1'b1;
      else if (do_pop & ~do_push)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/z80_bus_tracer.sv
// Z80 bus-cycle tracer: sync, decode, filter and queue bus cycles.
// Ports: Z80 strobes/a/d in, filter controls, record FIFO pop side, overflow.
module z80_bus_tracer
  import z80trace_pkg::*;
#(
  parameter int DEPTH_LOG2  = 4,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                           fclk,
  input  logic                           rst_n,
  input  logic                           m1_n,
  input  logic                           mreq_n,
  input  logic                           iorq_n,
  input  logic                           rd_n,
  input  logic                           wr_n,
  input  logic                           rfsh_n,
  input  logic [ADDR_W-1:0]              a,
  input  logic [DATA_W-1:0]              d,
  input  logic                           trace_en,
  input  logic [5:0]                     type_mask,
  input  logic                           dedup_en,
  output logic                           rec_valid,
  output logic [TYPE_W+ADDR_W+DATA_W-1:0] rec_data,
  input  logic                           rec_pop,
  output logic [DEPTH_LOG2:0]            rec_count,
  output logic                           overflow,
  output logic [7:0]                     drop_cnt,
  input  logic                           ovf_clr
);

  localparam int REC_W = rec_width(ADDR_W, DATA_W);

  logic [5:0]        ctl_s [SYNC_STAGES];
  logic [ADDR_W-1:0] a_p   [SYNC_STAGES];
  logic [DATA_W-1:0] d_p   [SYNC_STAGES];

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        ctl_s[i] <= '1;
        a_p[i]   <= '0;
        d_p[i]   <= '0;
      end
    end else begin
      ctl_s[0] <= {m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n};
      a_p[0]   <= a;
      d_p[0]   <= d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        ctl_s[i] <= ctl_s[i-1];
        a_p[i]   <= a_p[i-1];
        d_p[i]   <= d_p[i-1];
      end
    end
  end

  logic [5:0] ctl;
  logic m1, mreq, iorq, rd, wr, rfsh;
  logic mem_c, io_c;

  assign ctl = ~ctl_s[SYNC_STAGES-1];
  assign {m1, mreq, iorq, rd, wr, rfsh} = ctl;
  // Qualifiers keep the decode one-hot even for illegal strobe mixes.
  assign mem_c = mreq & ~iorq & ~rfsh;
  assign io_c  = iorq & ~mreq;

  logic      hit;
  cyc_type_t dec_type;

  always_comb begin
    hit      = 1'b1;
    dec_type = T_FETCH;
    unique case (1'b1)
      mem_c & m1 & rd & ~wr:   dec_type = T_FETCH;
      mem_c & ~m1 & rd & ~wr:  dec_type = T_MRD;
      mem_c & wr & ~rd:        dec_type = T_MWR;
      io_c & ~m1 & rd & ~wr:   dec_type = T_IORD;
      io_c & ~m1 & wr & ~rd:   dec_type = T_IOWR;
      io_c & m1:               dec_type = T_INTA;
      default:                 hit = 1'b0;
    endcase
  end

  trc_state_t        state;
  cyc_type_t         cur_type;
  cyc_type_t         type_q;
  logic              cur_en;
  logic              hit_q;
  logic              armed;
  logic [SYNC_STAGES-1:0] warm;
  logic [ADDR_W-1:0] cap_a;
  logic [DATA_W-1:0] cap_d;
  logic              last_valid;
  logic [ADDR_W-1:0] last_a;
  logic [DATA_W-1:0] last_d;
  logic              stable;

  // Two consecutive identical decodes filter 1-clock glitches.
  assign stable = hit & hit_q & (dec_type == type_q);

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cur_type   <= T_FETCH;
      type_q     <= T_FETCH;
      cur_en     <= 1'b0;
      hit_q      <= 1'b0;
      armed      <= 1'b0;
      warm       <= '0;
      cap_a      <= '0;
      cap_d      <= '0;
      last_valid <= 1'b0;
      last_a     <= '0;
      last_d     <= '0;
    end else begin
      hit_q  <= hit;
      type_q <= dec_type;
      // Arm only after the synchroniser holds real pin values and the
      // bus has been seen idle, so a cycle spanning reset is ignored.
      warm   <= {warm[SYNC_STAGES-2:0], 1'b1};
      if (warm[SYNC_STAGES-1] & ~hit) armed <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (armed & stable) begin
            state    <= S_ACTIVE;
            cur_type <= dec_type;
            cur_en   <= trace_en;
            cap_a    <= a_p[SYNC_STAGES-1];
            cap_d    <= d_p[SYNC_STAGES-1];
          end
        end
        S_ACTIVE: begin
          if (hit & (dec_type == cur_type)) begin
            cap_a <= a_p[SYNC_STAGES-1];
            cap_d <= d_p[SYNC_STAGES-1];
          end else begin
            state <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          state <= S_IDLE;
          if (cur_type == T_FETCH) begin
            last_valid <= 1'b1;
            last_a     <= cap_a;
            last_d     <= cap_d;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic             dup;
  logic             push;
  logic             drop;
  logic             empty;
  logic             full;
  logic [REC_W-1:0] wdata;

  assign dup   = dedup_en & (cur_type == T_FETCH) & last_valid
               & (last_a == cap_a) & (last_d == cap_d);
  assign push  = (state == S_COMMIT) & cur_en
               & type_mask[cur_type] & ~dup;
  assign wdata = {cur_type, cap_a, cap_d};

  z80trace_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (REC_W)
  ) u_fifo (
    .clk   (fclk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wdata),
    .pop   (rec_pop),
    .rdata (rec_data),
    .empty (empty),
    .full  (full),
    .count (rec_count),
    .drop  (drop)
  );

  assign rec_valid = ~empty;

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (ovf_clr)
        drop_cnt <= 8'd1;
      else if (drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_z80_bus_tracer.sv
// Directed and randomised bench for z80_bus_tracer.
// Drives Z80 strobes on negedge, samples outputs on negedge.
module tb_z80_bus_tracer;

  logic        fclk;
  logic        rst_n;
  logic        m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n;
  logic [15:0] a;
  logic [7:0]  d;
  logic        trace_en;
  logic [5:0]  type_mask;
  logic        dedup_en;
  logic        rec_valid;
  logic [26:0] rec_data;
  logic        rec_pop;
  logic [2:0]  rec_count;
  logic        overflow;
  logic [7:0]  drop_cnt;
  logic        ovf_clr;

  int checks = 0;
  int errors = 0;

  z80_bus_tracer #(
    .DEPTH_LOG2  (2),
    .ADDR_W      (16),
    .DATA_W      (8),
    .SYNC_STAGES (2)
  ) dut (
    .fclk      (fclk),
    .rst_n     (rst_n),
    .m1_n      (m1_n),
    .mreq_n    (mreq_n),
    .iorq_n    (iorq_n),
    .rd_n      (rd_n),
    .wr_n      (wr_n),
    .rfsh_n    (rfsh_n),
    .a         (a),
    .d         (d),
    .trace_en  (trace_en),
    .type_mask (type_mask),
    .dedup_en  (dedup_en),
    .rec_valid (rec_valid),
    .rec_data  (rec_data),
    .rec_pop   (rec_pop),
    .rec_count (rec_count),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt),
    .ovf_clr   (ovf_clr)
  );

  initial fclk = 1'b0;
  always #5 fclk = ~fclk;

  // t: 0..5 cycle types, 6 = refresh
  task automatic set_cyc(input int t, input logic on);
    m1_n   = !(on && (t == 0 || t == 5));
    mreq_n = !(on && (t == 0 || t == 1 || t == 2 || t == 6));
    iorq_n = !(on && (t == 3 || t == 4 || t == 5));
    rd_n   = !(on && (t == 0 || t == 1 || t == 3));
    wr_n   = !(on && (t == 2 || t == 4));
    rfsh_n = !(on && t == 6);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge fclk);
  endtask

  // Returns at the negedge where the strobes are released.
  task automatic run_cycle(input int t, input logic [15:0] ad,
                           input logic [7:0] dd, input int hold);
    @(negedge fclk);
    a = ad;
    d = dd;
    set_cyc(t, 1'b1);
    repeat (hold) @(negedge fclk);
    set_cyc(t, 1'b0);
  endtask

  task automatic pop_one();
    @(negedge fclk);
    rec_pop = 1'b1;
    @(negedge fclk);
    rec_pop = 1'b0;
  endtask

  task automatic check_outputs_reset(input string tag);
    checks++;
    if (rec_valid !== 1'b0 || rec_count !== 3'd0 || rec_data !== 27'd0 ||
        overflow !== 1'b0 || drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL %s: valid=%b count=%0d data=%h ovf=%b drop=%0d, want all 0",
               tag, rec_valid, rec_count, rec_data, overflow, drop_cnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rec_pop = 1'b0;
    ovf_clr = 1'b0;
    trace_en = 1'b1;
    type_mask = 6'h3F;
    dedup_en = 1'b0;
    a = '0;
    d = '0;
    set_cyc(0, 1'b0);
    idle(3);
    check_outputs_reset("reset_in");
    rst_n = 1'b1;
    idle(4);
    check_outputs_reset("reset_out");
  endtask

  task automatic test_mrd_latency();
    logic early;
    early = 1'b0;
    run_cycle(1, 16'h1234, 8'h5A, 3);
    repeat (3) begin
      @(posedge fclk);
      #1;
      if (rec_valid !== 1'b0) early = 1'b1;
    end
    checks++;
    if (early) begin
      errors++;
      $display("FAIL mrd_early: rec_valid=1 before 4th edge, want 0");
    end
    @(posedge fclk);
    #1;
    checks++;
    if (rec_valid !== 1'b1) begin
      errors++;
      $display("FAIL mrd_latency: rec_valid=%b at 4th edge, want 1", rec_valid);
    end
    @(negedge fclk);
    checks++;
    if (rec_count !== 3'd1 || rec_data !== {3'd1, 16'h1234, 8'h5A}) begin
      errors++;
      $display("FAIL mrd_record: count=%0d data=%h, want 1 %h",
               rec_count, rec_data, {3'd1, 16'h1234, 8'h5A});
    end
    pop_one();
    checks++;
    if (rec_valid !== 1'b0 || rec_count !== 3'd0) begin
      errors++;
      $display("FAIL mrd_pop: valid=%b count=%0d, want 0 0", rec_valid, rec_count);
    end
  endtask

  task automatic test_dedup();
    dedup_en = 1'b1;
    run_cycle(0, 16'h0038, 8'h3E, 3);
    idle(2);
    run_cycle(6, 16'h0005, 8'h00, 3);
    idle(2);
    run_cycle(0, 16'h0038, 8'h3E, 3);
    idle(6);
    checks++;
    if (rec_count !== 3'd1 || rec_data !== {3'd0, 16'h0038, 8'h3E}) begin
      errors++;
      $display("FAIL dedup_on: count=%0d data=%h, want 1 %h",
               rec_count, rec_data, {3'd0, 16'h0038, 8'h3E});
    end
    pop_one();
    dedup_en = 1'b0;
    run_cycle(0, 16'h0038, 8'h3E, 3);
    idle(2);
    run_cycle(6, 16'h0006, 8'h00, 3);
    idle(2);
    run_cycle(0, 16'h0038, 8'h3E, 3);
    idle(6);
    checks++;
    if (rec_count !== 3'd2 || rec_data !== {3'd0, 16'h0038, 8'h3E}) begin
      errors++;
      $display("FAIL dedup_off: count=%0d data=%h, want 2 %h",
               rec_count, rec_data, {3'd0, 16'h0038, 8'h3E});
    end
    pop_one();
    pop_one();
    checks++;
    if (rec_count !== 3'd0) begin
      errors++;
      $display("FAIL dedup_drain: count=%0d, want 0", rec_count);
    end
  endtask

  task automatic test_mask();
    type_mask = 6'h04;
    run_cycle(0, 16'h0100, 8'h21, 3);
    idle(2);
    run_cycle(1, 16'h0200, 8'h22, 3);
    idle(2);
    run_cycle(2, 16'h8000, 8'h11, 3);
    idle(2);
    run_cycle(4, 16'h00FE, 8'h07, 3);
    idle(6);
    checks++;
    if (rec_count !== 3'd1 || rec_data !== {3'd2, 16'h8000, 8'h11}) begin
      errors++;
      $display("FAIL mask: count=%0d data=%h, want 1 %h",
               rec_count, rec_data, {3'd2, 16'h8000, 8'h11});
    end
    pop_one();
    type_mask = 6'h3F;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 6; i++) begin
      run_cycle(2, 16'h0100 + 16'(i), 8'(i), 3);
      idle(6);
    end
    checks++;
    if (rec_count !== 3'd4 || overflow !== 1'b1 || drop_cnt !== 8'd2) begin
      errors++;
      $display("FAIL ovf_fill: count=%0d ovf=%b drop=%0d, want 4 1 2",
               rec_count, overflow, drop_cnt);
    end
    checks++;
    if (rec_data !== {3'd2, 16'h0100, 8'h00}) begin
      errors++;
      $display("FAIL ovf_head: data=%h, want %h", rec_data, {3'd2, 16'h0100, 8'h00});
    end
    // pop lands on the same edge as the push
    run_cycle(2, 16'h0106, 8'h06, 3);
    repeat (3) @(posedge fclk);
    @(negedge fclk);
    rec_pop = 1'b1;
    @(negedge fclk);
    rec_pop = 1'b0;
    checks++;
    if (rec_count !== 3'd4 || drop_cnt !== 8'd2 ||
        rec_data !== {3'd2, 16'h0101, 8'h01}) begin
      errors++;
      $display("FAIL push_pop_full: count=%0d drop=%0d data=%h, want 4 2 %h",
               rec_count, drop_cnt, rec_data, {3'd2, 16'h0101, 8'h01});
    end
    idle(3);
    @(negedge fclk);
    ovf_clr = 1'b1;
    @(negedge fclk);
    ovf_clr = 1'b0;
    checks++;
    if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL ovf_clr: ovf=%b drop=%0d, want 0 0", overflow, drop_cnt);
    end
    // clear coincides with a drop
    run_cycle(2, 16'h0107, 8'h07, 3);
    repeat (3) @(posedge fclk);
    @(negedge fclk);
    ovf_clr = 1'b1;
    @(negedge fclk);
    ovf_clr = 1'b0;
    checks++;
    if (overflow !== 1'b1 || drop_cnt !== 8'd1) begin
      errors++;
      $display("FAIL clr_vs_drop: ovf=%b drop=%0d, want 1 1", overflow, drop_cnt);
    end
    repeat (3) pop_one();
    checks++;
    if (rec_count !== 3'd1 || rec_data !== {3'd2, 16'h0106, 8'h06}) begin
      errors++;
      $display("FAIL ovf_tail: count=%0d data=%h, want 1 %h",
               rec_count, rec_data, {3'd2, 16'h0106, 8'h06});
    end
    pop_one();
    @(negedge fclk);
    ovf_clr = 1'b1;
    @(negedge fclk);
    ovf_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    run_cycle(2, 16'h4444, 8'h44, 3);
    idle(6);
    @(negedge fclk);
    a = 16'h00FE;
    d = 8'h99;
    set_cyc(4, 1'b1);
    idle(5);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(5);
    set_cyc(4, 1'b0);
    idle(8);
    check_outputs_reset("reset_mid");
    run_cycle(3, 16'h00FE, 8'h42, 3);
    idle(6);
    checks++;
    if (rec_count !== 3'd1 || rec_data !== {3'd3, 16'h00FE, 8'h42}) begin
      errors++;
      $display("FAIL after_reset_iord: count=%0d data=%h, want 1 %h",
               rec_count, rec_data, {3'd3, 16'h00FE, 8'h42});
    end
    pop_one();
  endtask

  task automatic test_glitch();
    run_cycle(1, 16'h5555, 8'h55, 1);
    idle(8);
    checks++;
    if (rec_valid !== 1'b0) begin
      errors++;
      $display("FAIL glitch: rec_valid=%b, want 0", rec_valid);
    end
  endtask

  task automatic test_random();
    int          t;
    logic [15:0] ra;
    logic [7:0]  rd;
    logic        exp_push;
    for (int i = 0; i < 300; i++) begin
      t         = $urandom_range(0, 5);
      ra        = 16'($urandom);
      rd        = 8'($urandom);
      type_mask = 6'($urandom_range(0, 63));
      trace_en  = ($urandom_range(0, 3) != 0);
      exp_push  = trace_en && type_mask[t];
      run_cycle(t, ra, rd, $urandom_range(2, 4));
      idle(6);
      checks++;
      if (exp_push) begin
        if (rec_valid !== 1'b1 || rec_data !== {3'(t), ra, rd}) begin
          errors++;
          $display("FAIL random_%0d: valid=%b data=%h, want 1 %h",
                   i, rec_valid, rec_data, {3'(t), ra, rd});
        end
        if (rec_valid === 1'b1) pop_one();
      end else if (rec_valid !== 1'b0) begin
        errors++;
        $display("FAIL random_%0d: valid=%b data=%h, want no record",
                 i, rec_valid, rec_data);
        pop_one();
      end
    end
    trace_en  = 1'b1;
    type_mask = 6'h3F;
  endtask

  initial begin
    test_reset();
    test_mrd_latency();
    test_dedup();
    test_mask();
    test_overflow();
    test_reset_mid();
    test_glitch();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
